// File: rtl/fmul16_sched_if.sv
// Request/response bundle for the two requesters sharing fmul16_sched.
// master = requester side, slave = scheduler side.
interface fmul16_sched_if;
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_ready;

    logic        rsp0_valid;
    logic [15:0] rsp0_result;
    logic [3:0]  rsp0_flags;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic [15:0] rsp1_result;
    logic [3:0]  rsp1_flags;
    logic        rsp1_ready;

    modport master (
        output req0_valid, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_flags
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_flags
    );
endinterface

// File: rtl/fmul16_sched.sv
// Round-robin scheduler sharing one external fp16 multiplier between two requesters.
// Optional macro FMUL_BYPASS_ZERO_EN: zero operands answer directly without waiting on the multiplier.
module fmul16_sched #(
    parameter int unsigned LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    fmul16_sched_if.slave        bus,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [15:0]          mul_result,
    input  logic [3:0]           mul_flags,
    output logic                 busy
);

    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("fmul16_sched: LAT must be within 1..15");
    end

    localparam logic [3:0] CntInit = 4'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic        r_last_grant;
    logic [15:0] r_mul_a;
    logic [15:0] r_mul_b;
    logic        r_rsp0_valid;
    logic [15:0] r_rsp0_result;
    logic [3:0]  r_rsp0_flags;
    logic        r_rsp1_valid;
    logic [15:0] r_rsp1_result;
    logic [3:0]  r_rsp1_flags;

    state_e      w_state_next;
    logic [3:0]  w_cnt_next;
    logic        w_owner_next;
    logic        w_last_next;
    logic [15:0] w_mul_a_next;
    logic [15:0] w_mul_b_next;
    logic        w_rsp0_valid_next;
    logic [15:0] w_rsp0_result_next;
    logic [3:0]  w_rsp0_flags_next;
    logic        w_rsp1_valid_next;
    logic [15:0] w_rsp1_result_next;
    logic [3:0]  w_rsp1_flags_next;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic [15:0] w_sel_a;
    logic [15:0] w_sel_b;
    logic        w_rsp_done;
    logic        w_cap;
    logic        w_cap_owner;
    logic [15:0] w_cap_result;
    logic [3:0]  w_cap_flags;

    // On contention the requester that did not win last time is granted.
    assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    assign w_ready0 = (r_state == StIdle) & w_grant0;
    assign w_ready1 = (r_state == StIdle) & w_grant1;
    assign w_accept = w_ready0 | w_ready1;

    assign w_sel_a    = w_grant1 ? bus.req1_a : bus.req0_a;
    assign w_sel_b    = w_grant1 ? bus.req1_b : bus.req0_b;
    assign w_rsp_done = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_owner_next       = r_owner;
        w_last_next        = r_last_grant;
        w_mul_a_next       = r_mul_a;
        w_mul_b_next       = r_mul_b;
        w_rsp0_valid_next  = r_rsp0_valid;
        w_rsp0_result_next = r_rsp0_result;
        w_rsp0_flags_next  = r_rsp0_flags;
        w_rsp1_valid_next  = r_rsp1_valid;
        w_rsp1_result_next = r_rsp1_result;
        w_rsp1_flags_next  = r_rsp1_flags;
        w_cap              = 1'b0;
        w_cap_owner        = r_owner;
        w_cap_result       = mul_result;
        w_cap_flags        = mul_flags;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_mul_a_next = w_sel_a;
                    w_mul_b_next = w_sel_b;
                    w_owner_next = w_grant1;
                    w_last_next  = w_grant1;
                    w_cnt_next   = CntInit;
                    w_state_next = StWait;
`ifdef FMUL_BYPASS_ZERO_EN
                    // A zero magnitude operand gives a signed zero; no need to wait.
                    if (w_sel_a[14:0] == 15'd0 || w_sel_b[14:0] == 15'd0) begin
                        w_state_next = StResp;
                        w_cap        = 1'b1;
                        w_cap_owner  = w_grant1;
                        w_cap_result = {w_sel_a[15] ^ w_sel_b[15], 15'd0};
                        w_cap_flags  = 4'b0100;
                    end
`endif
                end
            end
            StWait: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_cap        = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (w_rsp_done) begin
                    w_state_next = StIdle;
                    if (r_owner) begin
                        w_rsp1_valid_next = 1'b0;
                    end else begin
                        w_rsp0_valid_next = 1'b0;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase

        if (w_cap) begin
            if (w_cap_owner) begin
                w_rsp1_valid_next  = 1'b1;
                w_rsp1_result_next = w_cap_result;
                w_rsp1_flags_next  = w_cap_flags;
            end else begin
                w_rsp0_valid_next  = 1'b1;
                w_rsp0_result_next = w_cap_result;
                w_rsp0_flags_next  = w_cap_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_cnt         <= 4'd0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_mul_a       <= 16'd0;
            r_mul_b       <= 16'd0;
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= 16'd0;
            r_rsp0_flags  <= 4'd0;
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= 16'd0;
            r_rsp1_flags  <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_owner       <= w_owner_next;
            r_last_grant  <= w_last_next;
            r_mul_a       <= w_mul_a_next;
            r_mul_b       <= w_mul_b_next;
            r_rsp0_valid  <= w_rsp0_valid_next;
            r_rsp0_result <= w_rsp0_result_next;
            r_rsp0_flags  <= w_rsp0_flags_next;
            r_rsp1_valid  <= w_rsp1_valid_next;
            r_rsp1_result <= w_rsp1_result_next;
            r_rsp1_flags  <= w_rsp1_flags_next;
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp0_result = r_rsp0_result;
    assign bus.rsp0_flags  = r_rsp0_flags;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp1_result = r_rsp1_result;
    assign bus.rsp1_flags  = r_rsp1_flags;
    assign mul_a           = r_mul_a;
    assign mul_b           = r_mul_b;
    assign busy            = (r_state != StIdle);

endmodule

// File: tb/tb_fmul16_sched.sv
// Directed bench for fmul16_sched: one instance at LAT=1 and one at LAT=3,
// each with an XOR stand-in multiplier (flags fixed at 4'hA).
module tb_fmul16_sched;
    logic clk;
    logic reset;

    int n_cmp;
    int n_err;

    fmul16_sched_if bus1();
    fmul16_sched_if bus3();

    logic [15:0] mul_a1, mul_b1, mul_a3, mul_b3;
    logic [15:0] mul_res1, mul_res3;
    logic        busy1, busy3;

    assign mul_res1 = mul_a1 ^ mul_b1;
    assign mul_res3 = mul_a3 ^ mul_b3;

    fmul16_sched #(.LAT(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus1.slave),
        .mul_a      (mul_a1),
        .mul_b      (mul_b1),
        .mul_result (mul_res1),
        .mul_flags  (4'hA),
        .busy       (busy1)
    );

    fmul16_sched #(.LAT(3)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus3.slave),
        .mul_a      (mul_a3),
        .mul_b      (mul_b3),
        .mul_result (mul_res3),
        .mul_flags  (4'hA),
        .busy       (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.rsp0_ready = 1'b0;
        bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.rsp1_ready = 1'b0;
        bus3.req0_valid = 1'b0; bus3.req0_a = '0; bus3.req0_b = '0; bus3.rsp0_ready = 1'b0;
        bus3.req1_valid = 1'b0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.rsp1_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_mul_a", 32'(mul_a1), 32'd0);
        chk("rst_rsp0_valid", 32'(bus1.rsp0_valid), 32'd0);
        chk("rst_rsp1_result", 32'(bus3.rsp1_result), 32'd0);
        reset = 1'b0;

        // Round robin: both held valid, responses always consumed -> 0,1,0,1.
        bus1.req0_valid = 1'b1; bus1.req0_a = 16'h0003; bus1.req0_b = 16'h0001;
        bus1.req1_valid = 1'b1; bus1.req1_a = 16'h0030; bus1.req1_b = 16'h0010;
        bus1.rsp0_ready = 1'b1; bus1.rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready0", 32'(bus1.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", 32'(bus1.req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_wait_readys", 32'({bus1.req0_ready, bus1.req1_ready}), 32'd0);
            chk("rr_busy", 32'(busy1), 32'd1);
            tick();
            if (k % 2 == 0) begin
                chk("rr_rsp0_valid", 32'(bus1.rsp0_valid), 32'd1);
                chk("rr_rsp0_result", 32'(bus1.rsp0_result), 32'h0002);
                chk("rr_rsp1_idle", 32'(bus1.rsp1_valid), 32'd0);
            end else begin
                chk("rr_rsp1_valid", 32'(bus1.rsp1_valid), 32'd1);
                chk("rr_rsp1_result", 32'(bus1.rsp1_result), 32'h0020);
                chk("rr_rsp0_idle", 32'(bus1.rsp0_valid), 32'd0);
            end
            chk("rr_resp_readys", 32'({bus1.req0_ready, bus1.req1_ready}), 32'd0);
            tick();
        end
        bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
        bus1.rsp0_ready = 1'b0; bus1.rsp1_ready = 1'b0;
        tick();

        // LAT=1 single request from requester 0.
        bus1.req0_valid = 1'b1; bus1.req0_a = 16'h1234; bus1.req0_b = 16'h00FF;
        #1;
        chk("l1_ready0", 32'(bus1.req0_ready), 32'd1);
        chk("l1_ready1", 32'(bus1.req1_ready), 32'd0);
        tick();
        bus1.req0_valid = 1'b0; bus1.req0_a = 16'hDEAD;
        chk("l1_mul_a", 32'(mul_a1), 32'h1234);
        chk("l1_no_rsp_yet", 32'(bus1.rsp0_valid), 32'd0);
        tick();
        chk("l1_rsp0_valid", 32'(bus1.rsp0_valid), 32'd1);
        chk("l1_rsp0_result", 32'(bus1.rsp0_result), 32'h12CB);
        chk("l1_rsp0_flags", 32'(bus1.rsp0_flags), 32'hA);
        chk("l1_rsp1_valid", 32'(bus1.rsp1_valid), 32'd0);
        tick();
        chk("l1_rsp0_hold", 32'(bus1.rsp0_valid), 32'd1);
        bus1.rsp0_ready = 1'b1;
        tick();
        bus1.rsp0_ready = 1'b0;
        chk("l1_rsp0_drop", 32'(bus1.rsp0_valid), 32'd0);
        chk("l1_result_kept", 32'(bus1.rsp0_result), 32'h12CB);
        chk("l1_idle", 32'(busy1), 32'd0);
        chk("l1_mul_a_kept", 32'(mul_a1), 32'h1234);

        // LAT=3, requester 1, response held back for 5 cycles.
        bus3.req1_valid = 1'b1; bus3.req1_a = 16'hFFFF; bus3.req1_b = 16'h0F0F;
        #1;
        chk("l3_ready1", 32'(bus3.req1_ready), 32'd1);
        tick();
        bus3.req1_valid = 1'b0;
        bus3.req0_valid = 1'b1; bus3.req0_a = 16'h0005; bus3.req0_b = 16'h0001;
        bus3.rsp0_ready = 1'b1;
        tick();
        chk("l3_edge1", 32'(bus3.rsp1_valid), 32'd0);
        tick();
        chk("l3_edge2", 32'(bus3.rsp1_valid), 32'd0);
        chk("l3_ready0_wait", 32'(bus3.req0_ready), 32'd0);
        tick();
        chk("l3_edge3", 32'(bus3.rsp1_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("l3_hold_valid", 32'(bus3.rsp1_valid), 32'd1);
            chk("l3_hold_result", 32'(bus3.rsp1_result), 32'hF0F0);
            chk("l3_hold_flags", 32'(bus3.rsp1_flags), 32'hA);
            chk("l3_ready0_off", 32'(bus3.req0_ready), 32'd0);
            chk("l3_busy", 32'(busy3), 32'd1);
            tick();
        end
        bus3.rsp1_ready = 1'b1;
        tick();
        chk("l3_consumed", 32'(bus3.rsp1_valid), 32'd0);
        chk("l3_idle", 32'(busy3), 32'd0);
        chk("l3_ready0_now", 32'(bus3.req0_ready), 32'd1);
        bus3.req0_valid = 1'b0; bus3.rsp0_ready = 1'b0; bus3.rsp1_ready = 1'b0;
        tick();
        chk("l3_withdraw", 32'(busy3), 32'd0);

        // Reset pulse while in WAIT abandons the operation.
        bus3.req0_valid = 1'b1; bus3.req0_a = 16'h0002; bus3.req0_b = 16'h0003;
        tick();
        bus3.req0_valid = 1'b0;
        tick();
        chk("rw_in_wait", 32'(busy3), 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_busy", 32'(busy3), 32'd0);
        chk("rw_mul_a", 32'(mul_a3), 32'd0);
        chk("rw_rsp1_result", 32'(bus3.rsp1_result), 32'd0);
        chk("rw_dut1_result", 32'(bus1.rsp0_result), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("rw_no_rsp", 32'({bus3.rsp0_valid, bus3.rsp1_valid}), 32'd0);
            tick();
        end
        bus3.req0_valid = 1'b1; bus3.req1_valid = 1'b1;
        bus3.req1_a = 16'h8000; bus3.req1_b = 16'h4321;
        #1;
        chk("rw_grant0", 32'({bus3.req0_ready, bus3.req1_ready}), 32'b10);
        tick();
        bus3.req0_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rw_rsp0_valid", 32'(bus3.rsp0_valid), 32'd1);
        chk("rw_rsp0_result", 32'(bus3.rsp0_result), 32'h0001);
        chk("rw_req1_blocked", 32'(bus3.req1_ready), 32'd0);
        bus3.rsp0_ready = 1'b1;
        tick();
        bus3.rsp0_ready = 1'b0;

        // Zero-magnitude operand on requester 1 (still valid, now its turn).
        chk("bz_ready1", 32'(bus3.req1_ready), 32'd1);
        tick();
        bus3.req1_valid = 1'b0;
        chk("bz_mul_a", 32'(mul_a3), 32'h8000);
`ifdef FMUL_BYPASS_ZERO_EN
        chk("bz_valid", 32'(bus3.rsp1_valid), 32'd1);
        chk("bz_result", 32'(bus3.rsp1_result), 32'h8000);
        chk("bz_flags", 32'(bus3.rsp1_flags), 32'h4);
`else
        chk("bz_edge0", 32'(bus3.rsp1_valid), 32'd0);
        tick();
        chk("bz_edge1", 32'(bus3.rsp1_valid), 32'd0);
        tick();
        chk("bz_edge2", 32'(bus3.rsp1_valid), 32'd0);
        tick();
        chk("bz_valid", 32'(bus3.rsp1_valid), 32'd1);
        chk("bz_result", 32'(bus3.rsp1_result), 32'hC321);
        chk("bz_flags", 32'(bus3.rsp1_flags), 32'hA);
`endif
        bus3.rsp1_ready = 1'b1;
        tick();
        bus3.rsp1_ready = 1'b0;
        chk("bz_done", 32'(busy3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fmul16_sched.md
Name: fmul16_sched

Overview:
- Shares one 16-bit floating-point multiplier datapath between two requesters, e.g. the execute stage and a coprocessor port.
- Per requester: fair round-robin arbitration, a valid/ready request handshake and a held response.
- The multiplier sits outside this block. The block drives its operand inputs from registers and samples its result and flags after a fixed settle time.

Parameters:
- LAT, default 1: clock edges allowed for the multiplier to settle before its result is sampled. Legal range 1..15; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_a  in  16  requester 0 operand A
- req0_b  in  16  requester 0 operand B
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- rsp0_valid  out  1  response for requester 0 is held
- rsp0_result  out  16  product
- rsp0_flags  out  4  {neg, zero, carry, overflow}
- rsp0_ready  in  1  requester 0 consumes its response
- rsp1_valid, rsp1_result, rsp1_flags, rsp1_ready  same as requester 0, for requester 1
- mul_a  out  16  operand A to the multiplier, registered
- mul_b  out  16  operand B to the multiplier, registered
- mul_result  in  16  multiplier result
- mul_flags  in  4  multiplier flags
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, all outputs 0, mul_a/mul_b=0, cnt=0, owner=0, last_grant=1 (so requester 0 wins first).
- States: IDLE, WAIT, RESP.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) & reqN_valid & granted(N). This is combinational; at most one ready is high.
- IDLE, accept (valid & ready at an edge):
  - mul_a<=reqN_a, mul_b<=reqN_b.
  - owner<=N, last_grant<=N, cnt<=LAT-1.
  - Go to WAIT.
- WAIT:
  - cnt!=0: cnt decrements.
  - cnt==0: capture mul_result/mul_flags into rsp{owner}_result/flags, set rsp{owner}_valid, go to RESP.
  - rspN_valid therefore rises exactly LAT edges after the accepting edge.
- RESP:
  - rsp{owner}_valid stays high; result and flags are held stable until rsp{owner}_ready=1 at an edge.
  - On that edge: clear valid, go to IDLE. No accept on the same edge.
  - Minimum issue interval: LAT+2 cycles.
- Register-hold rules:
  - mul_a/mul_b hold their values from accept until the next accept, including across IDLE.
  - rspN_result/flags keep their last values after valid drops.
- Request rules:
  - A requester may drop reqN_valid before it is granted; this has no side effects.
  - Operands need not stay stable after accept.
  - rsp ready from the non-owner requester is ignored.
- Reset mid-operation: the operation in flight is abandoned and no response is produced after reset releases.
- Simultaneous events: if both requesters are valid in the same cycle the response handshake completes, the new grant takes effect the following cycle in IDLE.

Optional Feature:
- Macro: FMUL_BYPASS_ZERO_EN.
- Defined:
  - On accept, if reqN_a[14:0]==0 or reqN_b[14:0]==0, the state goes directly to RESP on the next edge, skipping WAIT.
  - Response: result={a[15]^b[15],15'b0}, flags=4'b0100.
  - mul_a/mul_b are still loaded.
  - Latency is 1 edge regardless of LAT.
- Not defined: zero operands take the normal LAT path and return the multiplier's outputs.

Test Plan:
- Bench multiplier model: mul_result = mul_a ^ mul_b, mul_flags = 4'hA.
- LAT=1, req0 a=16'h1234, b=16'h00FF -> req0_ready high in the same cycle; rsp0_valid high 1 edge later with result=16'h12CB, flags=4'hA; rsp1_valid stays 0.
- Both requesters held valid from reset, rsp ready tied high -> grant order 0,1,0,1; each request is accepted exactly once per handshake; never both readys high.
- LAT=3, req1 a=16'hFFFF, b=16'h0F0F; rsp1_ready held low 5 cycles -> rsp1_valid rises 3 edges after accept; result 16'hF0F0 stays stable; req0_ready stays 0 throughout; busy stays 1.
- Reset pulse while in WAIT -> all outputs 0 immediately; no rsp after release; next simultaneous request grants requester 0.
- FMUL_BYPASS_ZERO_EN defined, LAT=3, req1 a=16'h8000, b=16'h4321 -> rsp1_valid after 1 edge, result=16'h8000, flags=4'b0100.
- FMUL_BYPASS_ZERO_EN undefined, same stimulus -> result=16'hC321 after 3 edges.
